inst_rr_arbiter: RTL and testbench

INST_RR_ARBITER -- requirements
Module: inst_rr_arbiter

---
 rtl/inst_arb_pkg.sv | 21 ++
 rtl/rr_pick.sv | 40 ++++
 rtl/inst_rr_arbiter.sv | 129 ++++++++++++
 tb/tb_inst_rr_arbiter.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/inst_arb_pkg.sv
// Shared definitions for the instance round-robin arbiter: FSM state encoding,
// default sizing and the grant-id width derivation.
package inst_arb_pkg;

    localparam int N_REQ_DEFAULT   = 10;
    localparam int TIMEOUT_DEFAULT = 16;

    // Width needed to index n requesters; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int ID_W_DEFAULT = id_width(N_REQ_DEFAULT);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        RECOVER
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority search: first set request at or above ptr, wrapping
// modulo N_REQ. Purely combinational.
module rr_pick
    import inst_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEFAULT,
    parameter int ID_W  = id_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [ID_W-1:0]  winner,
    output logic             found
);

    // One extra bit holds ptr+i before the modulo fold (both operands < N_REQ).
    localparam logic [ID_W:0] N_EXT = (ID_W+1)'(N_REQ);

    logic [ID_W:0]   idx;
    logic [ID_W-1:0] cand;

    // Walk N_REQ positions starting at ptr and keep the first hit.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        cand   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = {1'b0, ptr} + (ID_W+1)'(i);
            if (idx >= N_EXT) begin
                idx = idx - N_EXT;
            end
            cand = idx[ID_W-1:0];
            if (!found && req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

endmodule

// File: rtl/inst_rr_arbiter.sv
// Round-robin arbiter granting one child instance at a time, with a hold
// timeout that forcibly revokes the grant and inserts a recovery cycle.
module inst_rr_arbiter
    import inst_arb_pkg::*;
#(
    parameter int N_REQ   = N_REQ_DEFAULT,
    parameter int TIMEOUT = TIMEOUT_DEFAULT,
    parameter int ID_W    = id_width(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] rel,
    output logic [N_REQ-1:0] gnt,
    output logic             gnt_valid,
    output logic [ID_W-1:0]  gnt_id,
    output logic             timeout_pulse,
    output logic [15:0]      grant_cnt
);

    localparam int              HOLD_W    = $clog2(TIMEOUT + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(TIMEOUT - 1);
    localparam logic [ID_W-1:0]   LAST_ID   = ID_W'(N_REQ - 1);

    arb_state_t        state;
    arb_state_t        state_next;
    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   owner;
    logic [ID_W-1:0]   winner;
    logic              found;
    logic [HOLD_W-1:0] hold_cnt;
    logic              owner_done;
    logic              hold_expired;

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .req    (req),
        .ptr    (ptr),
        .winner (winner),
        .found  (found)
    );

    // Only the owner's own release or dropped request ends a grant.
    assign owner_done   = rel[owner] | ~req[owner];
    assign hold_expired = (hold_cnt == HOLD_LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Owner, rotating pointer, hold timer and grant counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= '0;
            owner     <= '0;
            hold_cnt  <= '0;
            grant_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        owner     <= winner;
                        ptr       <= (winner == LAST_ID) ? '0 : winner + 1'b1;
                        hold_cnt  <= '0;
                        grant_cnt <= grant_cnt + 16'd1;
                    end
                end
                GRANT: begin
                    hold_cnt <= hold_cnt + 1'b1;
                end
                default: begin
                    hold_cnt <= '0;
                end
            endcase
        end
    end

    // Next-state logic; a release beats a simultaneous timeout.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (found) begin
                    state_next = GRANT;
                end
            end
            GRANT: begin
                if (owner_done) begin
                    state_next = IDLE;
                end else if (hold_expired) begin
                    state_next = RECOVER;
                end
            end
            RECOVER: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs decoded from registered state only, so they change on edges.
    always_comb begin
        gnt           = '0;
        gnt_id        = '0;
        timeout_pulse = 1'b0;
        case (state)
            GRANT: begin
                gnt[owner] = 1'b1;
                gnt_id     = owner;
            end
            RECOVER: begin
                timeout_pulse = 1'b1;
            end
            default: begin
            end
        endcase
        gnt_valid = |gnt;
    end

endmodule

// File: tb/tb_inst_rr_arbiter.sv
// Directed self-checking bench for inst_rr_arbiter with default parameters.
module tb_inst_rr_arbiter;

    logic        clk;
    logic        rst;
    logic [9:0]  req;
    logic [9:0]  rel;
    logic [9:0]  gnt;
    logic        gnt_valid;
    logic [3:0]  gnt_id;
    logic        timeout_pulse;
    logic [15:0] grant_cnt;

    int checks = 0;
    int errors = 0;

    inst_rr_arbiter #(
        .N_REQ   (10),
        .TIMEOUT (16),
        .ID_W    (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .rel           (rel),
        .gnt           (gnt),
        .gnt_valid     (gnt_valid),
        .gnt_id        (gnt_id),
        .timeout_pulse (timeout_pulse),
        .grant_cnt     (grant_cnt)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive inputs, then advance one edge and settle just past it.
    task automatic applyStimulus(input logic [9:0] r, input logic [9:0] l);
        req = r;
        rel = l;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        req = '0;
        rel = '0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Directed scenarios.
    initial begin
        logic [9:0] oh;
        int         exp_id;
        int         high;

        rst = 1'b1;
        req = '0;
        rel = '0;

        // Reset values.
        doReset();
        checkOutput("rst_gnt", 32'(gnt), 32'h0);
        checkOutput("rst_valid", 32'(gnt_valid), 32'h0);
        checkOutput("rst_id", 32'(gnt_id), 32'h0);
        checkOutput("rst_tmo", 32'(timeout_pulse), 32'h0);
        checkOutput("rst_cnt", 32'(grant_cnt), 32'h0);

        // All requesting, each owner releases after two cycles: 0..9 then 0.
        applyStimulus(10'h3FF, 10'h000);
        for (int k = 0; k <= 10; k++) begin
            exp_id = k % 10;
            oh     = 10'd1 << exp_id;
            checkOutput("rr_id", 32'(gnt_id), 32'(exp_id));
            checkOutput("rr_gnt", 32'(gnt), 32'(oh));
            applyStimulus(10'h3FF, 10'h000);
            checkOutput("rr_hold", 32'(gnt), 32'(oh));
            applyStimulus((k == 10) ? 10'h000 : 10'h3FF, oh);
            checkOutput("rr_gap", 32'(gnt_valid), 32'h0);
            checkOutput("rr_cnt", 32'(grant_cnt), 32'(k + 1));
            if (k < 10) begin
                applyStimulus(10'h3FF, 10'h000);
            end
        end

        // Wrap from ptr=5: inst_9 first, then inst_0, leaving ptr=1.
        doReset();
        applyStimulus(10'h010, 10'h000);
        checkOutput("wrap_setup_id", 32'(gnt_id), 32'd4);
        applyStimulus(10'h000, 10'h000);
        applyStimulus(10'h201, 10'h000);
        checkOutput("wrap_first_id", 32'(gnt_id), 32'd9);
        checkOutput("wrap_first_gnt", 32'(gnt), 32'h200);
        applyStimulus(10'h201, 10'h200);
        checkOutput("wrap_gap", 32'(gnt), 32'h0);
        applyStimulus(10'h201, 10'h000);
        checkOutput("wrap_second_id", 32'(gnt_id), 32'd0);
        applyStimulus(10'h000, 10'h000);
        applyStimulus(10'h003, 10'h000);
        checkOutput("wrap_ptr1_id", 32'(gnt_id), 32'd1);
        applyStimulus(10'h000, 10'h000);

        // Non-owner release is ignored.
        doReset();
        applyStimulus(10'h004, 10'h000);
        checkOutput("foreign_rel_pre", 32'(gnt), 32'h004);
        applyStimulus(10'h014, 10'h010);
        checkOutput("foreign_rel_gnt", 32'(gnt), 32'h004);
        checkOutput("foreign_rel_id", 32'(gnt_id), 32'd2);
        applyStimulus(10'h014, 10'h000);
        checkOutput("foreign_rel_post", 32'(gnt), 32'h004);
        applyStimulus(10'h000, 10'h000);

        // Timeout: 16 grant cycles, pulse, two low cycles, re-grant.
        doReset();
        applyStimulus(10'h008, 10'h000);
        high = 0;
        while (gnt[3] && high < 40) begin
            high++;
            applyStimulus(10'h008, 10'h000);
        end
        checkOutput("tmo_high_cycles", 32'(high), 32'd16);
        checkOutput("tmo_pulse", 32'(timeout_pulse), 32'h1);
        checkOutput("tmo_gnt_low1", 32'(gnt), 32'h0);
        applyStimulus(10'h008, 10'h000);
        checkOutput("tmo_gnt_low2", 32'(gnt), 32'h0);
        checkOutput("tmo_pulse_end", 32'(timeout_pulse), 32'h0);
        applyStimulus(10'h008, 10'h000);
        checkOutput("tmo_regrant", 32'(gnt), 32'h008);
        checkOutput("tmo_cnt", 32'(grant_cnt), 32'd2);
        applyStimulus(10'h000, 10'h000);

        // Release coinciding with the last hold cycle wins over timeout.
        doReset();
        applyStimulus(10'h008, 10'h000);
        repeat (15) applyStimulus(10'h008, 10'h000);
        checkOutput("relwin_last_hold", 32'(gnt), 32'h008);
        applyStimulus(10'h008, 10'h008);
        checkOutput("relwin_gnt", 32'(gnt), 32'h0);
        checkOutput("relwin_tmo", 32'(timeout_pulse), 32'h0);
        applyStimulus(10'h008, 10'h000);
        checkOutput("relwin_regrant", 32'(gnt), 32'h008);
        applyStimulus(10'h000, 10'h000);

        // Reset during a grant of inst_7; pending requests restart at ptr 0.
        doReset();
        applyStimulus(10'h080, 10'h000);
        checkOutput("midrst_owner", 32'(gnt_id), 32'd7);
        applyStimulus(10'h0A4, 10'h000);
        rst = 1'b1;
        applyStimulus(10'h0A4, 10'h000);
        checkOutput("midrst_gnt", 32'(gnt), 32'h0);
        checkOutput("midrst_valid", 32'(gnt_valid), 32'h0);
        checkOutput("midrst_cnt", 32'(grant_cnt), 32'h0);
        rst = 1'b0;
        applyStimulus(10'h0A4, 10'h000);
        checkOutput("midrst_next_id", 32'(gnt_id), 32'd2);
        checkOutput("midrst_next_gnt", 32'(gnt), 32'h004);
        checkOutput("midrst_next_cnt", 32'(grant_cnt), 32'd1);
        applyStimulus(10'h000, 10'h000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
